// File: rtl/sram_axi_master_if.sv
// sram_axi_master_if: single-beat AXI3 bundle between sram_axi_master and its responder
interface sram_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]          arid;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [3:0]          rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [3:0]          wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [3:0]          bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_master.sv
// sram_axi_master: SRAM-like CPU request port to single-beat AXI3 master, one transaction in flight
module sram_axi_master #(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                req,
    input  logic                wr,
    input  logic [1:0]          size,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    output logic                addr_ok,
    output logic                data_ok,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    sram_axi_master_if.master   m
);
    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                arvalid;
    logic                rready;
    logic                awvalid;
    logic                wvalid;
    logic                bready;
    logic                unused;

    assign addr_ok = aresetn && state == IDLE && req;

    assign m.arid    = AXI_ID;
    assign m.araddr  = addr_q;
    assign m.arlen   = 4'd0;
    assign m.arsize  = {1'b0, size_q};
    assign m.arburst = 2'b01;
    assign m.arlock  = 2'b00;
    assign m.arcache = 4'd0;
    assign m.arprot  = 3'd0;
    assign m.arvalid = arvalid;
    assign m.rready  = rready;
    assign m.awid    = AXI_ID;
    assign m.awaddr  = addr_q;
    assign m.awlen   = 4'd0;
    assign m.awsize  = {1'b0, size_q};
    assign m.awburst = 2'b01;
    assign m.awlock  = 2'b00;
    assign m.awcache = 4'd0;
    assign m.awprot  = 3'd0;
    assign m.awvalid = awvalid;
    assign m.wid     = AXI_ID;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = wstrb_q;
    assign m.wlast   = 1'b1;
    assign m.wvalid  = wvalid;
    assign m.bready  = bready;

    // single-beat, single-outstanding: response ids and rlast carry no information
    assign unused = ^{m.rid, m.rlast, m.bid};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            data_ok <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            data_ok <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    addr_q  <= addr;
                    size_q  <= size;
                    wstrb_q <= wstrb;
                    wdata_q <= wdata;
                    state   <= wr ? WR_AW_W : RD_AR;
                    arvalid <= !wr;
                    awvalid <= wr;
                    wvalid  <= wr;
                end
                RD_AR: if (m.arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= RD_R;
                end
                RD_R: if (m.rvalid) begin
                    rready  <= 1'b0;
                    rdata   <= m.rdata;
                    err     <= m.rresp != 2'b00;
                    data_ok <= 1'b1;
                    state   <= IDLE;
                end
                WR_AW_W: begin
                    if (m.awready) awvalid <= 1'b0;
                    if (m.wready) wvalid <= 1'b0;
                    // each channel is done once its valid is gone or handshakes this edge
                    if ((!awvalid || m.awready) && (!wvalid || m.wready)) begin
                        bready <= 1'b1;
                        state  <= WR_B;
                    end
                end
                WR_B: if (m.bvalid) begin
                    bready  <= 1'b0;
                    err     <= m.bresp != 2'b00;
                    data_ok <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_axi_master.sv
// tb_sram_axi_master: directed CPU transactions against a bench AXI responder,
// checked every cycle by a transaction-level model of the master
module tb_sram_axi_master;
    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] wdata = '0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    sram_axi_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    sram_axi_master #(.AXI_ID(4'd0), .ADDR_W(32), .DATA_W(32)) dut (
        .aclk(clk), .aresetn(aresetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .err(err), .m(axi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
    endtask

    // responder configuration
    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [1:0]  cfg_resp = 2'b00;
    // responder state
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit          r_pend, b_pend, aw_got, w_got;
    logic [31:0] r_addr, b_addr, w_data;
    logic [3:0]  w_strb;
    logic [31:0] smem [int];
    // model state
    logic [31:0] ref_mem [int];
    bit          busy, t_wr, t_err, ar_done, aw_done, w_done;
    logic [31:0] t_addr, t_wdata, t_exp, last_rdata;
    logic [1:0]  t_size;
    logic [3:0]  t_strb;
    // DUT outputs seen at the previous falling edge = values at the edge just past
    bit          s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, prev_rstn;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    bit          hs_ar, hs_r, hs_aw, hs_w, hs_b, exp_dok, exp_aok;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] sget(input logic [31:0] a);
        return smem.exists(int'(a >> 2)) ? smem[int'(a >> 2)] : 32'd0;
    endfunction

    function automatic logic [31:0] mget(input logic [31:0] a);
        return ref_mem.exists(int'(a >> 2)) ? ref_mem[int'(a >> 2)] : 32'd0;
    endfunction

    task automatic respond();
        if (!aresetn) begin
            axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
            return;
        end
        if (hs_ar) begin
            axi.arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0; r_addr = s_araddr;
        end else if (axi.arvalid && !axi.arready) begin
            if (ar_cnt >= ar_wait) axi.arready = 1; else ar_cnt++;
        end
        if (hs_r) axi.rvalid = 0;
        if (r_pend) begin
            if (r_cnt >= r_wait) begin
                axi.rvalid = 1; axi.rdata = sget(r_addr); axi.rresp = cfg_resp; r_pend = 0;
            end else r_cnt++;
        end
        if (hs_aw) begin
            axi.awready = 0; aw_cnt = 0; aw_got = 1; b_addr = s_awaddr;
        end else if (axi.awvalid && !axi.awready) begin
            if (aw_cnt >= aw_wait) axi.awready = 1; else aw_cnt++;
        end
        if (hs_w) begin
            axi.wready = 0; w_cnt = 0; w_got = 1; w_data = s_wdata; w_strb = s_wstrb;
        end else if (axi.wvalid && !axi.wready) begin
            if (w_cnt >= w_wait) axi.wready = 1; else w_cnt++;
        end
        if (aw_got && w_got) begin
            smem[int'(b_addr >> 2)] = merge(sget(b_addr), w_data, w_strb);
            aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
        end
        if (hs_b) axi.bvalid = 0;
        if (b_pend) begin
            if (b_cnt >= b_wait) begin
                axi.bvalid = 1; axi.bresp = cfg_resp; b_pend = 0;
            end else b_cnt++;
        end
    endtask

    // compare process: model of the master at transaction level, plus the responder
    initial begin
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 0; axi.rid = 0; axi.rlast = 1;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
        forever begin
            @(negedge clk);
            hs_ar = s_arvalid && axi.arready;
            hs_aw = s_awvalid && axi.awready;
            hs_w  = s_wvalid && axi.wready;
            hs_r  = axi.rvalid && s_rready;
            hs_b  = axi.bvalid && s_bready;
            if (!prev_rstn) begin
                check("rst_ctrl", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, data_ok, err}, 0);
                check("rst_rdata", rdata, 0);
                busy = 0;
                last_rdata = 0;
            end else begin
                if (busy) begin
                    if (hs_ar) ar_done = 1;
                    if (hs_aw) aw_done = 1;
                    if (hs_w) w_done = 1;
                end
                exp_dok = busy && (t_wr ? hs_b : hs_r);
                check("data_ok", data_ok, exp_dok);
                check("rdata", rdata, (exp_dok && !t_wr) ? t_exp : last_rdata);
                if (exp_dok) begin
                    check("err", err, t_err);
                    if (!t_wr) last_rdata = t_exp;
                    busy = 0;
                end
                check("arvalid", axi.arvalid, busy && !t_wr && !ar_done);
                check("rready", axi.rready, busy && !t_wr && ar_done);
                check("awvalid", axi.awvalid, busy && t_wr && !aw_done);
                check("wvalid", axi.wvalid, busy && t_wr && !w_done);
                check("bready", axi.bready, busy && t_wr && aw_done && w_done);
                if (axi.arvalid) begin
                    check("ar_fields", {axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
                          {4'd0, 4'd0, 1'b0, t_size, 2'b01, 2'b00, 4'd0, 3'd0});
                    check("araddr", axi.araddr, t_addr);
                end
                if (axi.awvalid) begin
                    check("aw_fields", {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
                          {4'd0, 4'd0, 1'b0, t_size, 2'b01, 2'b00, 4'd0, 3'd0});
                    check("awaddr", axi.awaddr, t_addr);
                end
                if (axi.wvalid) begin
                    check("w_fields", {axi.wid, axi.wlast, axi.wstrb}, {4'd0, 1'b1, t_strb});
                    check("wdata", axi.wdata, t_wdata);
                end
            end
            exp_aok = aresetn && req && !busy;
            check("addr_ok", addr_ok, exp_aok);
            if (exp_aok) begin
                busy = 1; t_wr = wr; t_addr = addr; t_size = size; t_strb = wstrb; t_wdata = wdata;
                t_err = cfg_resp != 2'b00; ar_done = 0; aw_done = 0; w_done = 0;
                if (wr) ref_mem[int'(addr >> 2)] = merge(mget(addr), wdata, wstrb);
                else t_exp = mget(addr);
            end
            respond();
            s_arvalid = axi.arvalid; s_araddr = axi.araddr;
            s_awvalid = axi.awvalid; s_awaddr = axi.awaddr;
            s_wvalid = axi.wvalid; s_wdata = axi.wdata; s_wstrb = axi.wstrb;
            s_rready = axi.rready; s_bready = axi.bready;
            prev_rstn = aresetn;
        end
    end

    task automatic wait_aok(output int t);
        t = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (addr_ok) begin
                t = cyc;
                return;
            end
        end
        timeout("addr_ok_wait");
    endtask

    task automatic cpu_txn(input bit w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] st, input int hold,
                           output logic [31:0] rd, output logic e, output int lat, output int n_aok);
        int t0;
        lat = -1; n_aok = 0; rd = 'x; e = 1'bx;
        @(posedge clk);
        #1 req = 1; wr = w; size = sz; addr = a; wdata = d; wstrb = st;
        wait_aok(t0);
        repeat (hold) begin
            @(negedge clk);
            if (addr_ok) n_aok++;
        end
        @(posedge clk);
        #1 req = 0;
        if (t0 < 0) return;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data_ok) begin
                rd = rdata; e = err; lat = cyc - t0;
                return;
            end
        end
        timeout("data_ok_wait");
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat, n_aok, t0, n_dok;

    initial begin
        smem[int'(32'h100 >> 2)] = 32'hDEADBEEF;
        ref_mem[int'(32'h100 >> 2)] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1 aresetn = 1;
        // zero-wait read
        cpu_txn(0, 2, 32'h100, 0, 0, 0, rd, e, lat, n_aok);
        check("rd0_latency", lat, 3);
        check("rd0_data", rd, 32'hDEADBEEF);
        check("rd0_err", e, 0);
        // write then read back
        cpu_txn(1, 2, 32'h40, 32'h12345678, 4'hF, 0, rd, e, lat, n_aok);
        check("wr1_latency", lat, 3);
        check("wr1_err", e, 0);
        check("wr1_rdata_kept", rd, 32'hDEADBEEF);
        cpu_txn(0, 2, 32'h40, 0, 0, 0, rd, e, lat, n_aok);
        check("rd1_data", rd, 32'h12345678);
        // partial strobes: bytes 0 and 2 replaced
        cpu_txn(1, 2, 32'h40, 32'hAABBCCDD, 4'b0101, 0, rd, e, lat, n_aok);
        cpu_txn(0, 2, 32'h40, 0, 0, 0, rd, e, lat, n_aok);
        check("rd2_strobe", rd, 32'h12BB56DD);
        // byte-size read carries arsize 0
        cpu_txn(0, 0, 32'h101, 0, 0, 0, rd, e, lat, n_aok);
        check("rd_byte_word", rd, 32'hDEADBEEF);
        // AW accepted at once, W three cycles late
        w_wait = 3;
        cpu_txn(1, 2, 32'h80, 32'hCAFEF00D, 4'hF, 0, rd, e, lat, n_aok);
        check("skew_latency", lat, 6);
        w_wait = 0;
        // AR backpressure with the request held
        ar_wait = 5;
        cpu_txn(0, 2, 32'h80, 0, 0, 4, rd, e, lat, n_aok);
        check("bp_no_second_aok", n_aok, 0);
        check("bp_latency", lat, 8);
        check("bp_data", rd, 32'hCAFEF00D);
        ar_wait = 0;
        // error responses, then recovery
        cfg_resp = 2'b10;
        cpu_txn(1, 2, 32'hC0, 32'h0BADC0DE, 4'hF, 0, rd, e, lat, n_aok);
        check("berr_err", e, 1);
        cfg_resp = 2'b11;
        cpu_txn(0, 2, 32'h100, 0, 0, 0, rd, e, lat, n_aok);
        check("rerr_err", e, 1);
        check("rerr_data", rd, 32'hDEADBEEF);
        cfg_resp = 2'b00;
        cpu_txn(0, 2, 32'hC0, 0, 0, 0, rd, e, lat, n_aok);
        check("ok_err", e, 0);
        check("ok_data", rd, 32'h0BADC0DE);
        // reset while waiting for read data
        r_wait = 6;
        @(posedge clk);
        #1 req = 1; wr = 0; size = 2; addr = 32'h100;
        wait_aok(t0);
        @(posedge clk);
        #1 req = 0;
        t0 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi.rready) begin
                t0 = cyc;
                break;
            end
        end
        if (t0 < 0) timeout("rready_wait");
        @(posedge clk);
        #1 aresetn = 0;
        @(posedge clk);
        #1 aresetn = 1;
        n_dok = 0;
        repeat (12) begin
            @(negedge clk);
            if (data_ok) n_dok++;
        end
        check("rst_no_data_ok", n_dok, 0);
        r_wait = 0;
        cpu_txn(0, 2, 32'h40, 0, 0, 0, rd, e, lat, n_aok);
        check("post_rst_latency", lat, 3);
        check("post_rst_data", rd, 32'h12BB56DD);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end
endmodule
